mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
//   Sits directly downstream of the register file: consumes the rs/rt read-port values
//   (RD1/RD2) for mult/multu/div/divu/mthi/mtlo, and supplies HI/LO to the write-back mux for mfhi/mflo.
//   Exposes a busy flag so the control/stall logic can hold later HI/LO users until the result lands.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-high; clears HI, LO and busy, aborts any operation
//   start    in   1   issue strobe; op/rs_val/rt_val sampled on the same clk edge
//   op       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_val   in   32  operand A / dividend / mthi-mtlo data (GRF RD1)
//   rt_val   in   32  operand B / divisor (GRF RD2)
//   busy     out  1   high while a mult/div is in flight
//   done     out  1   one-cycle pulse in the cycle HI/LO first show a new mult/div result
//   hi       out  32  HI register
//   lo       out  32  LO register
// BEHAVIOUR
//   Reset (async, any time): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, latched result dropped.
//   States: IDLE, RUN.
//   IDLE + start + op in {0..3}:
//     - capture the full 64-bit result; the product or quotient/remainder is computed from operands sampled at that edge
//     - next cycle: state=RUN, busy=1, counter=N-1 (N=MULT_CYCLES or DIV_CYCLES)
//   RUN: counter decrements each edge. At the edge where counter==0: hi/lo <= result, busy<=0, done<=1
//     for one cycle, state=IDLE. Busy is high for exactly N cycles; hi/lo are updated after the same edge
//     that drops busy.
//   hi/lo keep their old values throughout RUN.
//   IDLE + start + op=MTHI: hi <= rs_val next edge. op=MTLO: lo <= rs_val next edge. No busy, no done.
//   start with op 6/7: ignored entirely.
//   start while busy=1 (any op, including MTHI/MTLO): ignored, no effect on the running op or hi/lo.
//     The stall logic must prevent this case; the unit still tolerates it.
//   Same edge as completion (counter==0) with start=1: the completion still happens, and start is ignored.
//   MULT: signed 32x32 -> 64; hi=upper 32, lo=lower 32. MULTU: unsigned.
//   DIV: signed; lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
//     0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000 (no trap).
//   DIVU: unsigned quotient/remainder.
//   Divisor==0 (div or divu): full DIV_CYCLES busy and done pulse occur; hi/lo are left unchanged.
//   done=0 except the single pulse; busy and done are registered outputs (no combinational path from start).
// TESTING
//   1 reset, MULT rs=0xFFFFFFFF rt=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFFE, done pulse x1
//   2 MULTU rs=0xFFFFFFFF rt=0x00000002 -> hi=0x00000001 lo=0xFFFFFFFE; DIV rs=7 rt=0xFFFFFFFE -> lo=0xFFFFFFFD hi=0x00000001
//   3 MTHI rs=0x12345678, MTLO rs=0x9ABCDEF0 -> next edge hi/lo = those, busy stays 0; then DIVU rt=0 -> 10 busy cycles, hi/lo unchanged
//   4 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0; during its busy window issue MTLO 0xDEADBEEF and MULT -> both ignored
//   5 start MULT, assert reset asynchronously mid-RUN (between edges) -> busy, hi, lo drop to 0 immediately; no done pulse follows
//   6 back-to-back: MULT issued in the cycle right after done -> accepted; busy stays high for exactly MULT_CYCLES again

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed when the op is issued and lands in HI/LO after a fixed busy window.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        state_o
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    res_q, res_d;
    logic           skip_q, skip_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic           busy_q, busy_d, done_q, done_d;

    // One shared multiplier: signedness only changes how the operands are extended.
    logic        mul_sgn;
    logic [63:0] mul_a, mul_b, prod;
    assign mul_sgn = (op == OP_MULT);
    assign mul_a   = {{32{mul_sgn & rs_val[31]}}, rs_val};
    assign mul_b   = {{32{mul_sgn & rt_val[31]}}, rt_val};
    assign prod    = mul_a * mul_b;

    // One shared unsigned divider; signed division works on magnitudes and restores
    // signs afterwards, which also gives 0x80000000 / -1 = 0x80000000 without a trap.
    logic        div_sgn, rt_zero, neg_a, neg_b;
    logic [31:0] div_a, div_b, qmag, rmag, quo, rem;
    assign div_sgn = (op == OP_DIV);
    assign rt_zero = (rt_val == 32'd0);
    assign neg_a   = div_sgn & rs_val[31];
    assign neg_b   = div_sgn & rt_val[31];
    assign div_a   = neg_a ? (32'd0 - rs_val) : rs_val;
    assign div_b   = rt_zero ? 32'd1 : (neg_b ? (32'd0 - rt_val) : rt_val);
    assign qmag    = div_a / div_b;
    assign rmag    = div_a % div_b;
    assign quo     = (neg_a ^ neg_b) ? (32'd0 - qmag) : qmag;
    assign rem     = neg_a ? (32'd0 - rmag) : rmag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            skip_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            skip_q  <= skip_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        skip_d  = skip_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            res_d   = prod;
                            skip_d  = 1'b0;
                            cnt_d   = CW'(MULT_CYCLES - 1);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            res_d   = {rem, quo};
                            skip_d  = rt_zero;
                            cnt_d   = CW'(DIV_CYCLES - 1);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Any start seen while running is dropped, including on the completion edge.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!skip_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops
// compared against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy, done, state_o;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_hilo = '0;
    logic [63:0] exp_q[$];

    mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference: new {hi,lo} from the architectural rules, using wide integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] cur);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return cur;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            3'd4: return {a, cur[31:0]};
            3'd5: return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    task automatic fail_msg(input string name, input logic [63:0] got, input logic [63:0] exp);
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Issue one op at a negedge and follow it to completion, checking timing and HI/LO.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] old, e;
        int n, cyc;
        old = model_hilo;
        model_hilo = model(o, a, b, model_hilo);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        if (o <= 3'd3) begin
            n = (o < 3'd2) ? MULT_CYCLES : DIV_CYCLES;
            exp_q.push_back(model_hilo);
            cyc = 0;
            while (busy === 1'b1 && cyc < 200) begin
                cyc++;
                checks++;
                if ({hi, lo} !== old) fail_msg("hold_during_run", {hi, lo}, old);
                @(negedge clk);
            end
            checks++;
            if (cyc !== n) fail_msg("busy_length", 64'(cyc), 64'(n));
            checks++;
            if (done !== 1'b1) fail_msg("done_pulse", 64'(done), 64'd1);
            e = exp_q.pop_front();
            checks++;
            if ({hi, lo} !== e) fail_msg("result_hilo", {hi, lo}, e);
            @(negedge clk);
            checks++;
            if (done !== 1'b0) fail_msg("done_width", 64'(done), 64'd0);
        end else begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) fail_msg("mt_noop_flags", {62'd0, busy, done}, 64'd0);
            checks++;
            if ({hi, lo} !== model_hilo) fail_msg("mt_noop_hilo", {hi, lo}, model_hilo);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_hilo = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({hi, lo} !== 64'd0) fail_msg("reset_hilo", {hi, lo}, 64'd0);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) fail_msg("reset_flags", {62'd0, busy, done}, 64'd0);
    endtask

    task automatic test_directed();
        do_op(3'd0, 32'hFFFFFFFF, 32'h00000002);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) fail_msg("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        do_op(3'd1, 32'hFFFFFFFF, 32'h00000002);
        checks++;
        if ({hi, lo} !== 64'h00000001_FFFFFFFE) fail_msg("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
        do_op(3'd2, 32'd7, 32'hFFFFFFFE);
        checks++;
        if ({hi, lo} !== 64'h00000001_FFFFFFFD) fail_msg("div_const", {hi, lo}, 64'h00000001_FFFFFFFD);
    endtask

    task automatic test_mt_and_div_zero();
        do_op(3'd4, 32'h12345678, 32'h0);
        do_op(3'd5, 32'h9ABCDEF0, 32'h0);
        checks++;
        if ({hi, lo} !== 64'h12345678_9ABCDEF0) fail_msg("mthi_mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);
        do_op(3'd3, 32'h55555555, 32'h0);
        do_op(3'd2, 32'h80000000, 32'h0);
        checks++;
        if ({hi, lo} !== 64'h12345678_9ABCDEF0) fail_msg("div_by_zero_keep", {hi, lo}, 64'h12345678_9ABCDEF0);
        do_op(3'd6, 32'hAAAAAAAA, 32'h1);
        do_op(3'd7, 32'hBBBBBBBB, 32'h1);
    endtask

    task automatic test_busy_ignore();
        int cyc;
        model_hilo = model(3'd2, 32'h80000000, 32'hFFFFFFFF, model_hilo);
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'h80000000; rt_val = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b1; op = 3'd5; rs_val = 32'hDEADBEEF; rt_val = 32'h0;
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'h00000003; rt_val = 32'h00000004;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc !== DIV_CYCLES + 1) fail_msg("ignore_busy_len", 64'(cyc), 64'(DIV_CYCLES + 1));
        checks++;
        if ({hi, lo} !== 64'h00000000_80000000) fail_msg("div_overflow", {hi, lo}, 64'h00000000_80000000);
        checks++;
        if ({hi, lo} !== model_hilo) fail_msg("div_overflow_model", {hi, lo}, model_hilo);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) fail_msg("ignored_mult_not_started", 64'(busy), 64'd0);
    endtask

    task automatic test_async_reset();
        int dones;
        do_op(3'd4, 32'hCAFEF00D, 32'h0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'h1234; rt_val = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0) fail_msg("async_reset", {hi, lo} | 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_hilo = '0;
        dones = 0;
        for (int i = 0; i < MULT_CYCLES + 5; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) fail_msg("no_done_after_reset", 64'(dones), 64'd0);
        checks++;
        if ({hi, lo} !== 64'd0) fail_msg("hilo_after_reset", {hi, lo}, 64'd0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] e1;
        // First MULT; hold start high through its final busy cycle to hit the completion edge.
        e1 = model(3'd0, 32'hFFFF0001, 32'h00010003, model_hilo);
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'hFFFF0001; rt_val = 32'h00010003;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            if (cyc == MULT_CYCLES) begin
                start = 1'b1; op = 3'd1; rs_val = 32'h7; rt_val = 32'h9;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || {hi, lo} !== e1) fail_msg("b2b_first", {hi, lo}, e1);
        model_hilo = model(3'd0, 32'h80000001, 32'h7FFFFFFF, e1);
        // Issue during the done cycle: must be accepted.
        start = 1'b1; op = 3'd0; rs_val = 32'h80000001; rt_val = 32'h7FFFFFFF;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (cyc !== MULT_CYCLES) fail_msg("b2b_busy_len", 64'(cyc), 64'(MULT_CYCLES));
        checks++;
        if ({hi, lo} !== model_hilo) fail_msg("b2b_second", {hi, lo}, model_hilo);
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 16));
                default: ;
            endcase
            do_op(o, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt_and_div_zero();
        test_busy_ignore();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
